// File: rtl/csr_mmode_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_mmode_file_pkg
//  Description : Machine-mode CSR address map, access opcodes, mstatus field
//                positions and address-class helpers for csr_mmode_file.
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_mmode_file_pkg;

    // CSR instruction flavour as decoded by the execute stage
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Machine information registers (read-only space)
    localparam logic [11:0] c_csr_mvendorid = 12'hF11;
    localparam logic [11:0] c_csr_marchid   = 12'hF12;
    localparam logic [11:0] c_csr_mimpid    = 12'hF13;
    localparam logic [11:0] c_csr_mhartid   = 12'hF14;

    // Machine trap setup / handling
    localparam logic [11:0] c_csr_mstatus   = 12'h300;
    localparam logic [11:0] c_csr_misa      = 12'h301;
    localparam logic [11:0] c_csr_mie       = 12'h304;
    localparam logic [11:0] c_csr_mtvec     = 12'h305;
    localparam logic [11:0] c_csr_mscratch  = 12'h340;
    localparam logic [11:0] c_csr_mepc      = 12'h341;
    localparam logic [11:0] c_csr_mcause    = 12'h342;
    localparam logic [11:0] c_csr_mtval     = 12'h343;
    localparam logic [11:0] c_csr_mip       = 12'h344;

    // Machine counters; high halves live at +0x80
    localparam logic [11:0] c_csr_mcycle    = 12'hB00;
    localparam logic [11:0] c_csr_minstret  = 12'hB02;
    localparam logic [11:0] c_csr_mhpm_base = 12'hB03;
    localparam logic [11:0] c_csr_mcycleh   = 12'hB80;

    // mstatus bit positions
    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;

    // mcause interrupt flag position per XLEN
    localparam int c_mcause_int_bit_rv32 = 31;
    localparam int c_mcause_int_bit_rv64 = 63;

    // Addresses with [11:10]==2'b11 are read-only by encoding
    function automatic logic is_ro_addr(input logic [11:0] addr);
        return (addr[11:10] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_mmode_file_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit event counter with independent half-word writes.
//                Any write in a cycle suppresses that cycle's increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wdata,
    output logic [63:0] count
);

    logic [63:0] r_count;

    // Write replaces only the selected half(s); otherwise count on inc
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (wr_lo || wr_hi) begin
            r_count <= {(wr_hi ? wdata[63:32] : r_count[63:32]),
                        (wr_lo ? wdata[31:0]  : r_count[31:0])};
        end else if (inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_mmode_file.sv
`default_nettype none
// ============================================================================
//  Module      : csr_mmode_file
//  Description : Machine-mode CSR file. Combinational read beside execute,
//                write at the next edge; trap entry, mret and 64-bit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_mmode_file
    import csr_mmode_file_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NUM_HPM   = 4,
    parameter int unsigned     HART_ID   = 0,
    parameter logic [XLEN-1:0] MTVEC_RST = XLEN'(32'h0000_0100)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_valid,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [XLEN-1:0]    csr_wdata,
    input  logic               csr_wr_supp,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_illegal,
    input  logic               retire,
    input  logic [NUM_HPM-1:0] hpm_event,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_cause,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic [XLEN-1:0]    trap_tval,
    input  logic               mret_valid,
    output logic [XLEN-1:0]    trap_vector,
    output logic [XLEN-1:0]    mepc_o,
    output logic               mie_global
);

    localparam int        c_ncnt    = NUM_HPM + 2;
    localparam bit        c_rv64    = (XLEN == 64);
    localparam int        c_int_bit = c_rv64 ? c_mcause_int_bit_rv64 : c_mcause_int_bit_rv32;
    localparam logic [XLEN-1:0] c_mie_mask = XLEN'(12'h888);
    localparam logic [XLEN-1:0] c_misa = (XLEN'(1) << 8) | (XLEN'(c_rv64 ? 2 : 1) << (XLEN - 2));

    // Architectural state
    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    // Decode / datapath
    csr_op_e         w_op;
    logic            w_impl;
    logic            w_is_write;
    logic            w_illegal;
    logic            w_wr_en;
    logic [XLEN-1:0] w_rd_raw;
    logic [XLEN-1:0] w_new;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_base;

    // Counter access
    logic [4:0]        w_off;
    logic [4:0]        w_cnt_idx;
    logic              w_cnt_hi;
    logic              w_cnt_acc;
    logic              w_cnt_zero;
    logic              w_cnt_wr;
    logic [63:0]       w_cnt_val;
    logic [XLEN-1:0]   w_cnt_rd;
    logic [63:0]       w_cnt_wdata;
    logic [c_ncnt-1:0] w_inc;
    logic [63:0]       w_cnt_q [c_ncnt];

    assign w_op       = csr_op_e'(csr_op);
    assign w_off      = csr_addr[4:0];
    assign w_cnt_hi   = csr_addr[7];
    // mcycle is counter 0, minstret 1, mhpmcounterN is N-1
    assign w_cnt_idx  = (w_off == 5'd0) ? 5'd0 : (w_off - 5'd1);
    assign w_cnt_zero = (int'(w_off) >= int'(c_csr_mhpm_base[4:0]) + NUM_HPM);
    assign w_inc      = {hpm_event, retire, 1'b1};

    // Assemble mstatus; MPP is hardwired to machine mode
    always_comb begin
        w_mstatus                                     = '0;
        w_mstatus[c_mstatus_mie]                      = r_mstatus_mie;
        w_mstatus[c_mstatus_mpie]                     = r_mstatus_mpie;
        w_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo]  = 2'b11;
    end

    // Select the addressed counter and the requested half
    always_comb begin
        w_cnt_val = '0;
        for (int k = 0; k < c_ncnt; k++) begin
            if (int'(w_cnt_idx) == k) begin
                w_cnt_val = w_cnt_q[k];
            end
        end
        w_cnt_rd = XLEN'(w_cnt_hi ? (w_cnt_val >> 32) : w_cnt_val);
    end

    // Address decode and raw read value
    always_comb begin
        w_impl    = 1'b0;
        w_cnt_acc = 1'b0;
        w_rd_raw  = '0;
        case (csr_addr)
            c_csr_mvendorid, c_csr_marchid, c_csr_mimpid: w_impl = 1'b1;
            c_csr_mhartid:  begin w_impl = 1'b1; w_rd_raw = XLEN'(HART_ID); end
            c_csr_mstatus:  begin w_impl = 1'b1; w_rd_raw = w_mstatus;      end
            c_csr_misa:     begin w_impl = 1'b1; w_rd_raw = c_misa;         end
            c_csr_mie:      begin w_impl = 1'b1; w_rd_raw = r_mie;          end
            c_csr_mtvec:    begin w_impl = 1'b1; w_rd_raw = r_mtvec;        end
            c_csr_mscratch: begin w_impl = 1'b1; w_rd_raw = r_mscratch;     end
            c_csr_mepc:     begin w_impl = 1'b1; w_rd_raw = r_mepc;         end
            c_csr_mcause:   begin w_impl = 1'b1; w_rd_raw = r_mcause;       end
            c_csr_mtval:    begin w_impl = 1'b1; w_rd_raw = r_mtval;        end
            c_csr_mip:      w_impl = 1'b1;
            default: begin
                // 0xB00-0xB1F and 0xB80-0xB9F minus the unused 0xB01/0xB81;
                // high halves only exist on RV32
                if ((csr_addr[11:8] == c_csr_mcycle[11:8]) && (csr_addr[6:5] == 2'b00) &&
                    (w_off != 5'd1) && (!w_cnt_hi || !c_rv64)) begin
                    w_impl    = 1'b1;
                    w_cnt_acc = 1'b1;
                    w_rd_raw  = w_cnt_zero ? '0 : w_cnt_rd;
                end
            end
        endcase
    end

    assign w_is_write  = (w_op == CSR_OP_RW) ||
                         (((w_op == CSR_OP_RS) || (w_op == CSR_OP_RC)) && !csr_wr_supp);
    assign w_illegal   = csr_valid && (!w_impl || (is_ro_addr(csr_addr) && w_is_write));
    assign csr_illegal = w_illegal;
    assign csr_rdata   = (csr_valid && !w_illegal) ? w_rd_raw : '0;

    // Read-modify-write value for the three access flavours
    always_comb begin
        case (w_op)
            CSR_OP_RW: w_new = csr_wdata;
            CSR_OP_RS: w_new = w_rd_raw | csr_wdata;
            CSR_OP_RC: w_new = w_rd_raw & ~csr_wdata;
            default:   w_new = w_rd_raw;
        endcase
    end

    // Trap and mret take precedence over any CSR write in the same cycle
    assign w_wr_en  = csr_valid && !w_illegal && w_is_write && !trap_valid && !mret_valid;
    assign w_cnt_wr = w_wr_en && w_cnt_acc && !w_cnt_zero;

    // RV32 replicates the word so either half can be taken; RV64 keeps the low 64 bits
    assign w_cnt_wdata = 64'({w_new, w_new});

    generate
        for (genvar k = 0; k < c_ncnt; k++) begin : g_cnt
            logic w_sel;
            assign w_sel = w_cnt_wr && (int'(w_cnt_idx) == k);
            csr_counter64 u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (w_inc[k]),
                .wr_lo (w_sel && (c_rv64 || !w_cnt_hi)),
                .wr_hi (w_sel && (c_rv64 || w_cnt_hi)),
                .wdata (w_cnt_wdata),
                .count (w_cnt_q[k])
            );
        end
    endgenerate

    // Vectored mode only redirects interrupts
    assign w_base      = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_vector = (r_mtvec[0] && trap_cause[c_int_bit]) ?
                         (w_base + {trap_cause[XLEN-3:0], 2'b00}) : w_base;

    assign mepc_o     = r_mepc;
    assign mie_global = r_mstatus_mie;

    // Trap entry, mret and CSR writes in descending priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RST;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else if (trap_valid) begin
            r_mepc         <= {trap_pc[XLEN-1:2], 2'b00};
            r_mcause       <= trap_cause;
            r_mtval        <= trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mret_valid) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr_en) begin
            case (csr_addr)
                c_csr_mstatus: begin
                    r_mstatus_mie  <= w_new[c_mstatus_mie];
                    r_mstatus_mpie <= w_new[c_mstatus_mpie];
                end
                c_csr_mie:      r_mie      <= w_new & c_mie_mask;
                // Modes 2/3 are reserved: keep the previous mode bit
                c_csr_mtvec:    r_mtvec    <= {w_new[XLEN-1:2], 1'b0,
                                               (w_new[1] ? r_mtvec[0] : w_new[0])};
                c_csr_mscratch: r_mscratch <= w_new;
                c_csr_mepc:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
                c_csr_mcause:   r_mcause   <= w_new;
                c_csr_mtval:    r_mtval    <= w_new;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_mmode_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_mmode_file
//  Description : Directed self-checking bench for csr_mmode_file (RV32 with
//                two HPM counters, plus an RV64 instance for address checks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_mmode_file;
    import csr_mmode_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_wr_supp;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        retire;
    logic [1:0]  hpm_event;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic [31:0] trap_vector;
    logic [31:0] mepc_o;
    logic        mie_global;

    logic        v64;
    logic [1:0]  op64;
    logic [63:0] wdata64;
    logic        supp64;
    logic [63:0] rdata64;
    logic        illegal64;
    logic [63:0] zero64;
    logic [1:0]  zero_ev;
    logic        zero1;
    logic [63:0] tvec64;
    logic [63:0] mepc64;
    logic        mie64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csr_mmode_file #(.XLEN(32), .NUM_HPM(2), .HART_ID(3)) dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr),
        .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_wr_supp(csr_wr_supp),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .retire(retire),
        .hpm_event(hpm_event), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
        .trap_vector(trap_vector), .mepc_o(mepc_o), .mie_global(mie_global)
    );

    csr_mmode_file #(.XLEN(64), .NUM_HPM(2), .HART_ID(0)) dut64 (
        .clk(clk), .rst(rst), .csr_valid(v64), .csr_addr(csr_addr),
        .csr_op(op64), .csr_wdata(wdata64), .csr_wr_supp(supp64),
        .csr_rdata(rdata64), .csr_illegal(illegal64), .retire(zero1),
        .hpm_event(zero_ev), .trap_valid(zero1), .trap_cause(zero64),
        .trap_pc(zero64), .trap_tval(zero64), .mret_valid(zero1),
        .trap_vector(tvec64), .mepc_o(mepc64), .mie_global(mie64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge; outputs settle 1 time unit later
    task automatic step(input logic v, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic sp, input logic tv,
                        input logic mv, input logic [1:0] ev);
        @(negedge clk);
        csr_valid   = v;
        csr_addr    = a;
        csr_op      = op;
        csr_wdata   = wd;
        csr_wr_supp = sp;
        trap_valid  = tv;
        mret_valid  = mv;
        hpm_event   = ev;
        retire      = 1'b0;
        v64         = 1'b0;
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        step(1'b1, a, CSR_OP_RS, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        step(1'b1, a, CSR_OP_RW, d, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic idle();
        step(1'b0, 12'h000, CSR_OP_NONE, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic step64(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                          input logic sp);
        @(negedge clk);
        csr_valid = 1'b0;
        csr_addr  = a;
        v64       = 1'b1;
        op64      = op;
        wdata64   = wd;
        supp64    = sp;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        csr_valid = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0; csr_wr_supp = 1'b0;
        retire = 1'b0; hpm_event = '0; trap_valid = 1'b0; mret_valid = 1'b0;
        trap_cause = '0; trap_pc = '0; trap_tval = '0;
        v64 = 1'b0; op64 = '0; wdata64 = '0; supp64 = 1'b0;
        zero64 = '0; zero_ev = '0; zero1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_rdata",   csr_rdata,   32'h0);
        chk("rst_illegal", csr_illegal, 1'b0);
        chk("rst_mie",     mie_global,  1'b0);
        chk("rst_mepc",    mepc_o,      32'h0);
        chk("rst_tvec",    trap_vector, 32'h100);

        // Suppressed CSRRS is a pure read
        rd(c_csr_mtvec);
        chk("mtvec_rs_rd",  csr_rdata,   32'h100);
        chk("mtvec_rs_ill", csr_illegal, 1'b0);
        rd(c_csr_mstatus);
        chk("mstatus_rst",  csr_rdata,   32'h1800);
        rd(c_csr_mtvec);
        chk("mtvec_kept",   csr_rdata,   32'h100);

        // RV32 counter halves, carry and write-over-increment
        wr(c_csr_mcycle, 32'hFFFF_FFFF);
        idle();
        rd(c_csr_mcycle);
        chk("mcycle_wrap",  csr_rdata, 32'h0);
        rd(c_csr_mcycleh);
        chk("mcycleh_carry", csr_rdata, 32'h1);
        wr(c_csr_mcycleh, 32'h5);
        chk("mcycleh_old",  csr_rdata, 32'h1);
        rd(c_csr_mcycleh);
        chk("mcycleh_wr",   csr_rdata, 32'h5);
        rd(c_csr_mcycle);
        chk("mcycle_lo_hold", csr_rdata, 32'h3);

        // Scratch RW/RC and read-only violation
        wr(c_csr_mscratch, 32'hA5A5_A5A5);
        chk("mscratch_old", csr_rdata, 32'h0);
        step(1'b1, c_csr_mscratch, CSR_OP_RC, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("mscratch_rc_old", csr_rdata, 32'hA5A5_A5A5);
        rd(c_csr_mscratch);
        chk("mscratch_rc", csr_rdata, 32'hA5A5_A500);
        wr(c_csr_mhartid, 32'h1234);
        chk("mhartid_wr_ill",   csr_illegal, 1'b1);
        chk("mhartid_wr_rdata", csr_rdata,   32'h0);
        rd(c_csr_mhartid);
        chk("mhartid_val", csr_rdata,   32'h3);
        chk("mhartid_ill", csr_illegal, 1'b0);

        // Vectored interrupt trap and mret
        wr(c_csr_mtvec, 32'h201);
        wr(c_csr_mstatus, 32'h8);
        chk("mstatus_old", csr_rdata, 32'h1800);
        idle();
        chk("mie_set", mie_global, 1'b1);
        trap_cause = 32'h8000_0007; trap_pc = 32'h1002; trap_tval = 32'h55;
        step(1'b0, 12'h000, CSR_OP_NONE, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("tvec_irq", trap_vector, 32'h21C);
        idle();
        chk("trap_mepc", mepc_o,     32'h1000);
        chk("trap_mie",  mie_global, 1'b0);
        rd(c_csr_mstatus);
        chk("trap_mstatus", csr_rdata, 32'h1880);
        rd(c_csr_mcause);
        chk("trap_mcause", csr_rdata, 32'h8000_0007);
        rd(c_csr_mtval);
        chk("trap_mtval", csr_rdata, 32'h55);
        step(1'b0, 12'h000, CSR_OP_NONE, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00);
        idle();
        chk("mret_mie", mie_global, 1'b1);
        rd(c_csr_mstatus);
        chk("mret_mstatus", csr_rdata, 32'h1888);

        // Trap beats a same-cycle CSR write; exception ignores vectoring
        trap_cause = 32'h2; trap_pc = 32'h2004; trap_tval = 32'hDEAD;
        step(1'b1, c_csr_mepc, CSR_OP_RW, 32'h40, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("tvec_exc", trap_vector, 32'h200);
        idle();
        chk("trap_wins_mepc", mepc_o, 32'h2004);
        rd(c_csr_mstatus);
        chk("trap2_mstatus", csr_rdata, 32'h1880);
        wr(c_csr_mepc, 32'h43);
        idle();
        chk("mepc_warl", mepc_o, 32'h40);
        wr(c_csr_mtvec, 32'h302);
        chk("mtvec_old", csr_rdata, 32'h201);
        rd(c_csr_mtvec);
        chk("mtvec_mode_warl", csr_rdata, 32'h301);

        // HPM counters with NUM_HPM=2
        repeat (3) step(1'b0, 12'h000, CSR_OP_NONE, 32'h0, 1'b0, 1'b0, 1'b0, 2'b10);
        rd(12'hB04);
        chk("hpm4_count", csr_rdata, 32'h3);
        rd(12'hB03);
        chk("hpm3_idle", csr_rdata, 32'h0);
        rd(12'hB05);
        chk("hpm5_zero", csr_rdata,   32'h0);
        chk("hpm5_ill",  csr_illegal, 1'b0);
        wr(12'hB05, 32'h7);
        chk("hpm5_wr_ill", csr_illegal, 1'b0);
        rd(12'hB05);
        chk("hpm5_wr_ignored", csr_rdata, 32'h0);
        rd(12'h7C0);
        chk("unimpl_ill", csr_illegal, 1'b1);
        rd(12'hB85);
        chk("hpm5h_ill32", csr_illegal, 1'b0);

        // RV64 instance: high halves rejected, full-width datapath
        step64(12'hB80, CSR_OP_RS, 64'h0, 1'b1);
        chk("rv64_b80_ill",   illegal64, 1'b1);
        chk("rv64_b80_rdata", rdata64,   64'h0);
        step64(12'hB00, CSR_OP_RS, 64'h0, 1'b1);
        chk("rv64_b00_ill", illegal64, 1'b0);
        step64(c_csr_mscratch, CSR_OP_RW, 64'h1234_5678_9ABC_DEF0, 1'b0);
        step64(c_csr_mscratch, CSR_OP_RS, 64'h0, 1'b1);
        chk("rv64_mscratch", rdata64, 64'h1234_5678_9ABC_DEF0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
